issue_operand_pipe: RTL

- Parametrised elastic pipeline buffer between the scoreboard and issue-read-operands logic.
- Holds up to DEPTH issued instructions together with their source operands.
- While an entry waits, it snoops the writeback ports and captures any operand still outstanding.
- It supersedes the fixed single-register slice. It adds valid/ready backpressure, flush, configurable depth and operand count, and in-buffer forwarding.

---
 rtl/issue_operand_pipe_pkg.sv | 16 +
 rtl/issue_operand_pipe_if.sv | 46 ++++
 rtl/issue_operand_pipe_snoop.sv | 29 ++
 rtl/issue_operand_pipe.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/issue_operand_pipe_pkg.sv
// Shared defaults and helpers for the issue operand buffer.
package issue_operand_pipe_pkg;

    localparam int unsigned DEF_DEPTH         = 2;
    localparam int unsigned DEF_NR_OPERANDS   = 3;
    localparam int unsigned DEF_NR_WB_PORTS   = 4;
    localparam int unsigned DEF_DATA_WIDTH    = 64;
    localparam int unsigned DEF_TAG_WIDTH     = 3;
    localparam int unsigned DEF_PAYLOAD_WIDTH = 128;

    // Circular-buffer pointer step; DEPTH need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr + 32'd1 >= depth) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/issue_operand_pipe_if.sv
// Producer/consumer/writeback bundle of the issue operand buffer.
interface issue_operand_pipe_if
    import issue_operand_pipe_pkg::*;
#(
    parameter int unsigned DEPTH         = DEF_DEPTH,
    parameter int unsigned NR_OPERANDS   = DEF_NR_OPERANDS,
    parameter int unsigned NR_WB_PORTS   = DEF_NR_WB_PORTS,
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH     = DEF_TAG_WIDTH,
    parameter int unsigned PAYLOAD_WIDTH = DEF_PAYLOAD_WIDTH
) ();
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                                      flush_i;
    logic                                      in_valid_i;
    logic                                      in_ready_o;
    logic [PAYLOAD_WIDTH-1:0]                  in_payload_i;
    logic [NR_OPERANDS-1:0][DATA_WIDTH-1:0]    in_op_i;
    logic [NR_OPERANDS-1:0]                    in_op_valid_i;
    logic [NR_OPERANDS-1:0][TAG_WIDTH-1:0]     in_op_tag_i;
    logic [NR_WB_PORTS-1:0]                    wb_valid_i;
    logic [NR_WB_PORTS-1:0][TAG_WIDTH-1:0]     wb_trans_id_i;
    logic [NR_WB_PORTS-1:0][DATA_WIDTH-1:0]    wb_data_i;
    logic                                      out_valid_o;
    logic                                      out_ready_i;
    logic [PAYLOAD_WIDTH-1:0]                  out_payload_o;
    logic [NR_OPERANDS-1:0][DATA_WIDTH-1:0]    out_op_o;
    logic [NR_OPERANDS-1:0]                    out_op_valid_o;
    logic                                      out_all_op_valid_o;
    logic [CNT_W-1:0]                          occupancy_o;

    modport slave (
        input  flush_i, in_valid_i, in_payload_i, in_op_i, in_op_valid_i, in_op_tag_i,
               wb_valid_i, wb_trans_id_i, wb_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_payload_o, out_op_o, out_op_valid_o,
               out_all_op_valid_o, occupancy_o
    );

    modport master (
        output flush_i, in_valid_i, in_payload_i, in_op_i, in_op_valid_i, in_op_tag_i,
               wb_valid_i, wb_trans_id_i, wb_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_payload_o, out_op_o, out_op_valid_o,
               out_all_op_valid_o, occupancy_o
    );

endinterface

// File: rtl/issue_operand_pipe_snoop.sv
// Matches one operand tag against all writeback ports; lowest port index wins.
module issue_operand_snoop
    import issue_operand_pipe_pkg::*;
#(
    parameter int unsigned NR_WB_PORTS = DEF_NR_WB_PORTS,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH   = DEF_TAG_WIDTH
) (
    input  logic [TAG_WIDTH-1:0]                   tag_i,
    input  logic [NR_WB_PORTS-1:0]                 wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][TAG_WIDTH-1:0]  wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][DATA_WIDTH-1:0] wb_data_i,
    output logic                                   hit_o,
    output logic [DATA_WIDTH-1:0]                  data_o
);

    // Scan from the top so the lowest matching port overwrites last.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
            if (wb_valid_i[p] && (wb_trans_id_i[p] == tag_i)) begin
                hit_o  = 1'b1;
                data_o = wb_data_i[p];
            end
        end
    end

endmodule

// File: rtl/issue_operand_pipe.sv
// Elastic buffer between scoreboard and issue-read-operands; waiting entries
// capture outstanding operands from the writeback ports.
module issue_operand_pipe
    import issue_operand_pipe_pkg::*;
#(
    parameter int unsigned DEPTH         = DEF_DEPTH,
    parameter int unsigned NR_OPERANDS   = DEF_NR_OPERANDS,
    parameter int unsigned NR_WB_PORTS   = DEF_NR_WB_PORTS,
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned TAG_WIDTH     = DEF_TAG_WIDTH,
    parameter int unsigned PAYLOAD_WIDTH = DEF_PAYLOAD_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    issue_operand_pipe_if.slave  bus
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [PAYLOAD_WIDTH-1:0]               payload;
        logic [NR_OPERANDS-1:0][DATA_WIDTH-1:0] op;
        logic [NR_OPERANDS-1:0]                 op_valid;
        logic [NR_OPERANDS-1:0][TAG_WIDTH-1:0]  tag;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    entry_t           in_entry;
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             push, pop;

    logic [DEPTH-1:0][NR_OPERANDS-1:0]                 st_hit;
    logic [DEPTH-1:0][NR_OPERANDS-1:0][DATA_WIDTH-1:0] st_data;
    logic [NR_OPERANDS-1:0]                            in_hit;
    logic [NR_OPERANDS-1:0][DATA_WIDTH-1:0]            in_data;

    // Flush wins over both handshakes; ready_q is a flop so out_ready_i never reaches in_ready_o.
    assign push = bus.in_valid_i && ready_q && !bus.flush_i;
    assign pop  = (cnt_q != '0) && bus.out_ready_i && !bus.flush_i;

    for (genvar d = 0; d < DEPTH; d++) begin : g_st_entry
        for (genvar o = 0; o < NR_OPERANDS; o++) begin : g_st_op
            issue_operand_snoop #(
                .NR_WB_PORTS (NR_WB_PORTS),
                .DATA_WIDTH  (DATA_WIDTH),
                .TAG_WIDTH   (TAG_WIDTH)
            ) u_snoop (
                .tag_i         (mem_q[d].tag[o]),
                .wb_valid_i    (bus.wb_valid_i),
                .wb_trans_id_i (bus.wb_trans_id_i),
                .wb_data_i     (bus.wb_data_i),
                .hit_o         (st_hit[d][o]),
                .data_o        (st_data[d][o])
            );
        end
    end

    for (genvar o = 0; o < NR_OPERANDS; o++) begin : g_in_op
        issue_operand_snoop #(
            .NR_WB_PORTS (NR_WB_PORTS),
            .DATA_WIDTH  (DATA_WIDTH),
            .TAG_WIDTH   (TAG_WIDTH)
        ) u_snoop (
            .tag_i         (bus.in_op_tag_i[o]),
            .wb_valid_i    (bus.wb_valid_i),
            .wb_trans_id_i (bus.wb_trans_id_i),
            .wb_data_i     (bus.wb_data_i),
            .hit_o         (in_hit[o]),
            .data_o        (in_data[o])
        );
    end

    always_comb begin
        in_entry         = '0;
        in_entry.payload = bus.in_payload_i;
        in_entry.tag     = bus.in_op_tag_i;
        for (int o = 0; o < NR_OPERANDS; o++) begin
            in_entry.op[o]       = (!bus.in_op_valid_i[o] && in_hit[o]) ? in_data[o] : bus.in_op_i[o];
            in_entry.op_valid[o] = bus.in_op_valid_i[o] | in_hit[o];
        end
    end

    // Snoop only fills pending operands; the push then overrides the free slot.
    always_comb begin
        for (int d = 0; d < DEPTH; d++) begin
            mem_d[d] = mem_q[d];
            for (int o = 0; o < NR_OPERANDS; o++) begin
                if (!mem_q[d].op_valid[o] && st_hit[d][o]) begin
                    mem_d[d].op[o]       = st_data[d][o];
                    mem_d[d].op_valid[o] = 1'b1;
                end
            end
        end
        if (push) mem_d[wptr_q] = in_entry;
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (bus.flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) wptr_d = PTR_W'(wrap_inc(32'(wptr_q), DEPTH));
            if (pop)  rptr_d = PTR_W'(wrap_inc(32'(rptr_q), DEPTH));
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
        ready_d = (cnt_d != FULL_CNT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int d = 0; d < DEPTH; d++) mem_q[d] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            for (int d = 0; d < DEPTH; d++) mem_q[d] <= mem_d[d];
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign bus.in_ready_o         = ready_q;
    assign bus.out_valid_o        = (cnt_q != '0);
    assign bus.out_payload_o      = mem_q[rptr_q].payload;
    assign bus.out_op_o           = mem_q[rptr_q].op;
    assign bus.out_op_valid_o     = mem_q[rptr_q].op_valid;
    assign bus.out_all_op_valid_o = &mem_q[rptr_q].op_valid;
    assign bus.occupancy_o        = cnt_q;

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(push && (cnt_q == FULL_CNT)));
            assert (!(pop && (cnt_q == '0)));
        end
    end

endmodule
